// File: rtl/dragon_pkg.sv
// Shared types and helpers for the dragon body controller.
// Positions are packed {y, x}, one nibble each.
package dragon_pkg;

  localparam int POS_W        = 8;
  localparam int COORD_W      = 4;
  localparam int NUM_SEGMENTS = 7;
  localparam int GRID_W       = 16;
  localparam int GRID_H       = 12;
  localparam int LEN_W        = 3;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } pos_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  function automatic pos_t pack_pos(input logic [COORD_W-1:0] y, input logic [COORD_W-1:0] x);
    pos_t p;
    p.y = y;
    p.x = x;
    return p;
  endfunction

  function automatic logic [COORD_W-1:0] pos_x(input pos_t p);
    return p.x;
  endfunction

  function automatic logic [COORD_W-1:0] pos_y(input pos_t p);
    return p.y;
  endfunction

  // Compared as int so the full-width grid dimension does not produce a
  // constant comparison on the 4-bit coordinate.
  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] c, input int lim);
    if (int'(c) > lim) return COORD_W'(lim);
    return c;
  endfunction

  function automatic logic [COORD_W-1:0] step_toward(input logic [COORD_W-1:0] c, input logic [COORD_W-1:0] t);
    if (c < t) return c + 4'd1;
    if (c > t) return c - 4'd1;
    return c;
  endfunction

  function automatic logic [NUM_SEGMENTS-1:0] active_mask(input logic [LEN_W-1:0] len);
    logic [NUM_SEGMENTS-1:0] m;
    for (int i = 0; i < NUM_SEGMENTS; i++) m[i] = (i < int'(len));
    return m;
  endfunction

endpackage

// File: rtl/dragon_head_step.sv
// Combinational head stepper: moves the head one cell toward the clamped
// target. Optional macro DRAGON_DIAGONAL_EN lets x and y step together;
// otherwise x is resolved first, then y.
module dragon_head_step
  import dragon_pkg::*;
(
  input  pos_t head_pos,
  input  pos_t target_pos,
  output pos_t next_head
);

  logic [COORD_W-1:0] tx, ty, hx, hy, nx, ny;

  // Clamp the target into the grid, then pick the single (or diagonal) step.
  always_comb begin
    tx = clamp_coord(pos_x(target_pos), GRID_W - 1);
    ty = clamp_coord(pos_y(target_pos), GRID_H - 1);
    hx = pos_x(head_pos);
    hy = pos_y(head_pos);
    nx = step_toward(hx, tx);
    ny = step_toward(hy, ty);
`ifdef DRAGON_DIAGONAL_EN
    next_head = pack_pos(ny, nx);
`else
    next_head = (hx != tx) ? pack_pos(hy, nx) : pack_pos(ny, hx);
`endif
  end

endmodule

// File: rtl/dragon_body_controller.sv
// Dragon head/body position controller. Steps the head toward target_pos
// every MOVE_PERIOD frame ticks and shifts the body behind it.
// Optional macro DRAGON_DIAGONAL_EN (in dragon_head_step) enables diagonal steps.
//
// state   | meaning
// S_IDLE  | waiting for a pending move request
// S_STEP  | capture the stepped head; skip the shift if it would not move
// S_SHIFT | shift body, load new head, pulse positions_valid
module dragon_body_controller
  import dragon_pkg::*;
#(
  parameter int         MOVE_PERIOD = 4,
  parameter logic [7:0] HEAD_START  = 8'h55
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            frame_tick,
  input  logic [POS_W-1:0]                target_pos,
  input  logic                            grow,
  input  logic                            shrink,
  output logic [NUM_SEGMENTS*POS_W-1:0]   segment_positions,
  output logic [NUM_SEGMENTS-1:0]         segment_active,
  output logic [LEN_W-1:0]                length,
  output logic                            positions_valid
);

  localparam int CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick_fire;
  logic             move_req;
  state_t           state, state_nxt;
  pos_t             seg [NUM_SEGMENTS];
  pos_t             next_head;
  pos_t             step_pos;
  logic             consume, load_next, do_shift;
  logic [LEN_W-1:0] len_nxt;

  assign tick_fire = frame_tick && (tick_cnt == CNT_W'(MOVE_PERIOD - 1));

  dragon_head_step u_head_step (
    .head_pos   (seg[0]),
    .target_pos (target_pos),
    .next_head  (step_pos)
  );

  // Frame tick counter, free-running regardless of FSM state.
  always_ff @(posedge clk) begin
    if (!reset)          tick_cnt <= '0;
    else if (frame_tick) tick_cnt <= tick_fire ? '0 : tick_cnt + 1'b1;
  end

  // Sticky move request; a new request wins over consumption in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset)         move_req <= 1'b0;
    else if (tick_fire) move_req <= 1'b1;
    else if (consume)   move_req <= 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state and control decode.
  always_comb begin
    state_nxt = state;
    consume   = 1'b0;
    load_next = 1'b0;
    do_shift  = 1'b0;
    case (state)
      S_IDLE: begin
        if (move_req) begin
          consume   = 1'b1;
          state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        load_next = 1'b1;
        state_nxt = (step_pos == seg[0]) ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        do_shift  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Segment shift register, captured head and update strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SEGMENTS; i++) seg[i] <= HEAD_START;
      next_head       <= HEAD_START;
      positions_valid <= 1'b0;
    end else begin
      positions_valid <= do_shift;
      if (load_next) next_head <= step_pos;
      if (do_shift) begin
        for (int i = 1; i < NUM_SEGMENTS; i++) seg[i] <= seg[i-1];
        seg[0] <= next_head;
      end
    end
  end

  // Saturating length update; simultaneous grow and shrink cancel.
  always_comb begin
    len_nxt = length;
    if (grow && !shrink && (length < LEN_W'(NUM_SEGMENTS))) len_nxt = length + 1'b1;
    else if (shrink && !grow && (length > LEN_W'(1)))       len_nxt = length - 1'b1;
  end

  // Length and active mask registered together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      length         <= LEN_W'(1);
      segment_active <= NUM_SEGMENTS'(1);
    end else begin
      length         <= len_nxt;
      segment_active <= active_mask(len_nxt);
    end
  end

  for (genvar g = 0; g < NUM_SEGMENTS; g++) begin : g_bus
    assign segment_positions[g*POS_W +: POS_W] = seg[g];
  end

endmodule

// File: tb/tb_dragon_body_controller.sv
// Directed bench for dragon_body_controller (default MOVE_PERIOD = 4).
module tb_dragon_body_controller;
  import dragon_pkg::*;

  localparam int MP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [7:0]  target_pos;
  logic        grow;
  logic        shrink;
  logic [55:0] segment_positions;
  logic [6:0]  segment_active;
  logic [2:0]  length;
  logic        positions_valid;

  int checks = 0;
  int errors = 0;

  dragon_body_controller #(.MOVE_PERIOD(MP), .HEAD_START(8'h55)) dut (
    .clk               (clk),
    .reset             (reset),
    .frame_tick        (frame_tick),
    .target_pos        (target_pos),
    .grow              (grow),
    .shrink            (shrink),
    .segment_positions (segment_positions),
    .segment_active    (segment_active),
    .length            (length),
    .positions_valid   (positions_valid)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One move period of ticks, then watch a bounded window for the strobe.
  task automatic do_move(output logic seen);
    seen = 1'b0;
    repeat (MP) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (positions_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   vcnt;

    reset = 1'b0; frame_tick = 1'b0; target_pos = 8'h55; grow = 1'b0; shrink = 1'b0;
    cyc(); cyc();

    chk("rst_bus",    segment_positions, 56'h55555555555555);
    chk("rst_len",    length, 3'd1);
    chk("rst_active", segment_active, 7'b0000001);
    chk("rst_valid",  positions_valid, 1'b0);

    reset = 1'b1;
    cyc();

    // Target equals head: ticks fire but nothing moves.
    target_pos = 8'h55;
    vcnt = 0;
    for (int m = 0; m < 2; m++) begin
      do_move(seen);
      if (seen) vcnt++;
    end
    chk("hold_no_strobe", vcnt, 0);
    chk("hold_bus", segment_positions, 56'h55555555555555);

    // Three ticks are not enough for a move.
    target_pos = 8'h58;
    repeat (MP - 1) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    end
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (positions_valid) vcnt++;
    end
    chk("no_early_move", vcnt, 0);
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (positions_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("move1_strobe", seen, 1'b1);
    chk("move1_bus", segment_positions, 56'h55555555555556);
    cyc();
    chk("move1_strobe_1cyc", positions_valid, 1'b0);
    chk("move1_bus_stable", segment_positions, 56'h55555555555556);

    do_move(seen);
    chk("move2_strobe", seen, 1'b1);
    chk("move2_bus", segment_positions, 56'h55555555555657);

    // Length growth / shrink with saturation.
    grow = 1'b1; cyc(); grow = 1'b0;
    chk("grow1_len", length, 3'd2);
    chk("grow1_active", segment_active, 7'b0000011);
    grow = 1'b1; repeat (7) cyc(); grow = 1'b0;
    chk("grow_sat_len", length, 3'd7);
    chk("grow_sat_active", segment_active, 7'b1111111);
    grow = 1'b1; shrink = 1'b1; cyc(); grow = 1'b0; shrink = 1'b0;
    chk("grow_shrink_len", length, 3'd7);
    shrink = 1'b1; cyc(); shrink = 1'b0;
    chk("shrink1_len", length, 3'd6);
    chk("shrink1_active", segment_active, 7'b0111111);
    shrink = 1'b1; repeat (7) cyc(); shrink = 1'b0;
    chk("shrink_sat_len", length, 3'd1);
    chk("shrink_sat_active", segment_active, 7'b0000001);

    // Walk the head to 0xBE.
    target_pos = 8'hBE;
    do_move(seen);
`ifdef DRAGON_DIAGONAL_EN
    chk("path_first_head", segment_positions[7:0], 8'h68);
`else
    chk("path_first_head", segment_positions[7:0], 8'h58);
`endif
    for (int m = 0; m < 20; m++) begin
      if (segment_positions[7:0] == 8'hBE) break;
      do_move(seen);
    end
`ifdef DRAGON_DIAGONAL_EN
    chk("path_bus", segment_positions, 56'h68798A9BACBDBE);
`else
    chk("path_bus", segment_positions, 56'h5E6E7E8E9EAEBE);
`endif

    // Out-of-grid target clamps to (x=15, y=11).
    target_pos = 8'hFF;
    do_move(seen);
    chk("clamp_step_strobe", seen, 1'b1);
    chk("clamp_step_head", segment_positions[7:0], 8'hBF);
    do_move(seen);
    chk("clamp_hold_strobe", seen, 1'b0);
    chk("clamp_hold_head", segment_positions[7:0], 8'hBF);

    // Decrementing step.
    target_pos = 8'h00;
    do_move(seen);
    chk("dec_strobe", seen, 1'b1);
`ifdef DRAGON_DIAGONAL_EN
    chk("dec_head", segment_positions[7:0], 8'hAE);
`else
    chk("dec_head", segment_positions[7:0], 8'hBE);
`endif

    // Reset while in S_STEP.
    grow = 1'b1; cyc(); grow = 1'b0;
    repeat (MP) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (dut.state == S_STEP) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    chk("reach_step", seen, 1'b1);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("rst2_state", dut.state, S_IDLE);
    chk("rst2_bus", segment_positions, 56'h55555555555555);
    chk("rst2_len", length, 3'd1);
    chk("rst2_active", segment_active, 7'b0000001);
    chk("rst2_valid", positions_valid, 1'b0);
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (positions_valid) vcnt++;
    end
    chk("rst2_no_strobe", vcnt, 0);
    chk("rst2_bus_hold", segment_positions, 56'h55555555555555);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
